sprite_loader: RTL and testbench

- Write-side counterpart to the sprite pixel ROMs: fills a 32x32, 2-bit-per-pixel sprite image from a byte stream (host/UART bridge) using a valid/ready handshake.
- Double-buffered. The VGA path reads a stable front bank with the same horz/vert → 2-bit pixel-code contract as the sprite ROMs. The back bank is loaded.
- Banks swap only on a frame_sync pulse (vsync) after a complete image has been loaded, so the display never shows a partial sprite.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_loader_if.sv | 14 +
 rtl/sprite_bank_ram.sv | 32 +++
 rtl/sprite_loader.sv | 170 +++++++++++++++++
 tb/tb_sprite_loader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite loader slice.
//   pix_t          - 2-bit pixel code, 00 is transparent
//   ld_state_e     - loader FSM states
//   pix_pick()     - extracts one pixel from a packed 4-pixel byte
package sprite_pkg;

  localparam int SPR_W_DEF    = 32;
  localparam int SPR_H_DEF    = 32;
  localparam int PIX_BITS_DEF = 2;

  typedef logic [1:0] pix_t;
  localparam pix_t PIX_TRANSPARENT = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } ld_state_e;

  // Leftmost pixel lives in the MSBs: idx 0 -> [7:6], idx 3 -> [1:0].
  function automatic pix_t pix_pick(input logic [7:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    return b[7:6];
      2'd1:    return b[5:4];
      2'd2:    return b[3:2];
      default: return b[1:0];
    endcase
  endfunction

endpackage

// File: rtl/sprite_loader_if.sv
// Byte-stream handshake into the sprite loader.
//   in_data  - four packed pixels, leftmost in [7:6]
//   in_valid - in_data valid
//   in_sof   - byte is byte 0 of an image
//   in_ready - loader accepts this cycle
interface sprite_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_sof, input in_ready);
  modport slave  (input in_data, input in_valid, input in_sof, output in_ready);
endinterface

// File: rtl/sprite_bank_ram.sv
// One sprite bank: simple dual-port RAM, one write port and one
// registered read port. No reset on the array or the read register;
// the consumer masks the output until the bank holds a valid image.
//   clk     - clock
//   we      - write enable
//   waddr   - write address
//   wdata   - write data
//   raddr   - read address
//   rd_data - data at raddr, one cycle later
module sprite_bank_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data_q <= mem[raddr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_loader.sv
// Double-buffered sprite image loader. A byte stream fills the back
// bank; a frame_sync pulse after a complete image swaps banks so the
// display only ever sees whole sprites.
//   clk, rst   - clock, synchronous active-high reset
//   s_if       - byte-stream handshake (slave side)
//   frame_sync - vsync pulse, the only swap point
//   horz, vert - sprite-local read coordinates
//   draw_pixel - pixel code at (horz, vert), one cycle later
//   busy       - loader not idle
//   load_done  - pulse on the cycle after a swap
//   err_sync   - pulse when a non-SOF byte is dropped while idle
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int SPR_W    = SPR_W_DEF,
  parameter int SPR_H    = SPR_H_DEF,
  parameter int PIX_BITS = PIX_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  sprite_loader_if.slave        s_if,
  input  logic                  frame_sync,
  input  logic [9:0]            horz,
  input  logic [9:0]            vert,
  output pix_t                  draw_pixel,
  output logic                  busy,
  output logic                  load_done,
  output logic                  err_sync
);

  localparam int PPB   = 8 / PIX_BITS;        // pixels per byte
  localparam int WPR   = SPR_W / PPB;         // bytes per row
  localparam int DEPTH = WPR * SPR_H;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // ---- loader state ----
  ld_state_e     state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          disp_bank_q, disp_bank_d;
  logic          front_valid_q, front_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          load_done_q, load_done_d;
  logic          err_sync_q, err_sync_d;

  // ---- read pipeline ----
  logic          rd_ok_q, rd_ok_d;
  logic [1:0]    pix_sel_q, pix_sel_d;
  logic          rd_bank_q, rd_bank_d;

  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [1:0][7:0] bank_rd;

  assign accept = s_if.in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    disp_bank_d   = disp_bank_q;
    front_valid_d = front_valid_q;
    load_done_d   = 1'b0;
    err_sync_d    = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = wr_addr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_if.in_sof) begin
            wr_en     = 1'b1;
            wr_addr   = '0;
            wr_addr_d = AW'(1);
            state_d   = LOAD;
          end else begin
            err_sync_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (s_if.in_sof) begin
            // restart: the new image overwrites from address 0
            wr_addr   = '0;
            wr_addr_d = AW'(1);
          end else if (wr_addr_q == LAST) begin
            wr_addr_d = '0;
            state_d   = PENDING;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      PENDING: begin
        if (frame_sync) begin
          disp_bank_d   = ~disp_bank_q;
          front_valid_d = 1'b1;
          load_done_d   = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != PENDING);
    busy_d     = (state_d != IDLE);
  end

  // Range check on the full-width coordinates; the address is only
  // narrowed afterwards so out-of-range values cannot alias in-range ones.
  always_comb begin
    rd_ok_d   = (horz < 10'(SPR_W)) && (vert < 10'(SPR_H)) && front_valid_q;
    pix_sel_d = horz[1:0];
    rd_bank_d = disp_bank_q;
    rd_addr   = AW'(({10'd0, vert} * 20'(WPR)) + {12'd0, horz[9:2]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      disp_bank_q   <= 1'b0;
      front_valid_q <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
      err_sync_q    <= 1'b0;
      rd_ok_q       <= 1'b0;
      pix_sel_q     <= '0;
      rd_bank_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      disp_bank_q   <= disp_bank_d;
      front_valid_q <= front_valid_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      load_done_q   <= load_done_d;
      err_sync_q    <= err_sync_d;
      rd_ok_q       <= rd_ok_d;
      pix_sel_q     <= pix_sel_d;
      rd_bank_q     <= rd_bank_d;
    end
  end

  // Both banks read every cycle; writes only hit the back bank.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    sprite_bank_ram #(.AW(AW), .DW(8)) u_ram (
      .clk     (clk),
      .we      (wr_en && (disp_bank_q != 1'(b))),
      .waddr   (wr_addr),
      .wdata   (s_if.in_data),
      .raddr   (rd_addr),
      .rd_data (bank_rd[b])
    );
  end

  // Bank mux sits after the RAM read registers, using the bank captured
  // alongside the address so a swap never mixes banks within one read.
  assign draw_pixel    = rd_ok_q ? pix_pick(bank_rd[rd_bank_q], pix_sel_q) : PIX_TRANSPARENT;
  assign s_if.in_ready = in_ready_q;
  assign busy          = busy_q;
  assign load_done     = load_done_q;
  assign err_sync      = err_sync_q;

endmodule

// File: tb/tb_sprite_loader.sv
module tb_sprite_loader;
  import sprite_pkg::*;

  logic       clk;
  logic       rst;
  logic       frame_sync;
  logic [9:0] horz, vert;
  pix_t       draw_pixel;
  logic       busy, load_done, err_sync;

  int n_chk  = 0;
  int n_fail = 0;

  sprite_loader_if s_if ();

  sprite_loader u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_if       (s_if),
    .frame_sync (frame_sync),
    .horz       (horz),
    .vert       (vert),
    .draw_pixel (draw_pixel),
    .busy       (busy),
    .load_done  (load_done),
    .err_sync   (err_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives n back-to-back bytes; byte 0 is d0 (with SOF if sof0), the rest d.
  // Optionally raises frame_sync together with the last byte.
  task automatic send_stream(input int n, input logic [7:0] d0, input logic [7:0] d,
                             input bit sof0, input bit fs_last);
    for (int i = 0; i < n; i++) begin
      s_if.in_valid = 1'b1;
      s_if.in_data  = (i == 0) ? d0 : d;
      s_if.in_sof   = sof0 && (i == 0);
      frame_sync    = fs_last && (i == n - 1);
      @(posedge clk); #1;
    end
    s_if.in_valid = 1'b0;
    s_if.in_sof   = 1'b0;
    frame_sync    = 1'b0;
  endtask

  task automatic fsync();
    frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
  endtask

  task automatic read_px(input string tag, input int x, input int y, input pix_t exp);
    horz = 10'(x);
    vert = 10'(y);
    @(posedge clk); #1;
    chk(tag, 32'(draw_pixel), 32'(exp));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    frame_sync = 1'b0;
    horz = '0;
    vert = '0;
    s_if.in_valid = 1'b0;
    s_if.in_sof   = 1'b0;
    s_if.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_if.in_ready), 1);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_pix",   32'(draw_pixel), 0);
    chk("rst_done",  32'(load_done), 0);
    chk("rst_err",   32'(err_sync), 0);
    rst = 1'b0;

    read_px("pre_swap_5_5", 5, 5, 2'b00);

    // stray non-SOF byte in IDLE
    s_if.in_valid = 1'b1; s_if.in_data = 8'hFF; s_if.in_sof = 1'b0;
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    chk("err_pulse",  32'(err_sync), 1);
    chk("err_busy",   32'(busy), 0);
    chk("err_ready",  32'(s_if.in_ready), 1);
    idle_cycle();
    chk("err_clear",  32'(err_sync), 0);

    // full image of E4
    send_stream(256, 8'hE4, 8'hE4, 1'b1, 1'b0);
    chk("e4_ready_pend", 32'(s_if.in_ready), 0);
    chk("e4_busy_pend",  32'(busy), 1);
    chk("e4_nodone",     32'(load_done), 0);
    read_px("e4_preswap", 0, 0, 2'b00);
    fsync();
    chk("e4_done",       32'(load_done), 1);
    chk("e4_ready_idle", 32'(s_if.in_ready), 1);
    chk("e4_busy_idle",  32'(busy), 0);
    idle_cycle();
    chk("e4_done_once",  32'(load_done), 0);
    read_px("e4_0_0",   0, 0,  2'b11);
    read_px("e4_1_0",   1, 0,  2'b10);
    read_px("e4_2_0",   2, 0,  2'b01);
    read_px("e4_3_0",   3, 0,  2'b00);
    read_px("e4_29_31", 29, 31, 2'b10);
    read_px("e4_32_0",  32, 0, 2'b00);
    read_px("e4_0_40",  0, 40, 2'b00);

    // restart mid-load: 100 bytes, then SOF 55 + 255 bytes of 1B
    send_stream(100, 8'hAA, 8'hAA, 1'b1, 1'b0);
    send_stream(255, 8'h55, 8'h1B, 1'b1, 1'b0);
    chk("rs_ready_255", 32'(s_if.in_ready), 1);
    chk("rs_busy_255",  32'(busy), 1);
    send_stream(1, 8'h1B, 8'h1B, 1'b0, 1'b0);
    chk("rs_ready_256", 32'(s_if.in_ready), 0);
    fsync();
    chk("rs_done", 32'(load_done), 1);
    read_px("rs_0_0", 0, 0, 2'b01);
    read_px("rs_4_0", 4, 0, 2'b00);
    read_px("rs_5_0", 5, 0, 2'b01);
    read_px("rs_6_0", 6, 0, 2'b10);
    read_px("rs_7_0", 7, 0, 2'b11);

    // frame_sync while idle must not swap
    fsync();
    chk("idle_fs_done", 32'(load_done), 0);
    read_px("idle_fs_img", 0, 0, 2'b01);

    // frame_sync coincident with final byte: no swap until the next one
    send_stream(256, 8'hFF, 8'hFF, 1'b1, 1'b1);
    chk("fsl_ready", 32'(s_if.in_ready), 0);
    chk("fsl_nodone", 32'(load_done), 0);
    read_px("fsl_old_img", 0, 0, 2'b01);
    chk("fsl_still_pend", 32'(s_if.in_ready), 0);
    fsync();
    chk("fsl_done", 32'(load_done), 1);
    read_px("fsl_new_img", 0, 0, 2'b11);

    // reset in the middle of a load
    send_stream(128, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("mid_busy", 32'(busy), 1);
    horz = '0; vert = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ready", 32'(s_if.in_ready), 1);
    chk("mrst_busy",  32'(busy), 0);
    chk("mrst_pix",   32'(draw_pixel), 0);
    rst = 1'b0;
    read_px("mrst_nofront", 0, 0, 2'b00);
    send_stream(256, 8'h9C, 8'h9C, 1'b1, 1'b0);
    chk("mrst_pend", 32'(s_if.in_ready), 0);
    fsync();
    chk("mrst_done", 32'(load_done), 1);
    read_px("mrst_0_0", 0, 0, 2'b10);
    read_px("mrst_1_0", 1, 0, 2'b01);
    read_px("mrst_2_0", 2, 0, 2'b11);
    read_px("mrst_3_0", 3, 0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
